// File: rtl/sd_cmd_shift_engine.sv
// Bidirectional MSB-first shift engine for the SD CMD line with start-bit detect and RX timeout.
// Optional CRC7 insertion/check when SD_CMD_CRC7_EN is defined.
module sd_cmd_shift_engine #(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 8
) (
    input  logic             iClock_SD,
    input  logic             iReset,
    input  logic             iEnable,
    input  logic             iStart,
    input  logic             iMode,
    input  logic [WIDTH-1:0] iParallel,
    input  logic             iSerial,
    output logic             oSerial,
    output logic             oSerialOe,
    output logic [WIDTH-1:0] oParallel,
    output logic             oBusy,
    output logic             oComplete,
    output logic             oTimeout,
    output logic             oCrcErr
);

    typedef enum logic [1:0] {IDLE, TX_SHIFT, RX_WAIT, RX_SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] frame;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] idx;
    logic [TO_W-1:0]  to_next;

    // Bit position handled on the current edge: cnt counts bits already on the line / captured.
    assign idx     = CNT_W'(WIDTH - 1) - cnt;
    assign to_next = to_cnt + TO_W'(1);

`ifdef SD_CMD_CRC7_EN
    logic [6:0] crc;
    logic       crc_err;

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    assign oCrcErr = crc_err;
`else
    assign oCrcErr = 1'b0;
`endif

    always_ff @(posedge iClock_SD) begin
        if (!iReset) begin
            state     <= IDLE;
            frame     <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            oSerial   <= 1'b1;
            oSerialOe <= 1'b0;
            oParallel <= '0;
            oBusy     <= 1'b0;
            oComplete <= 1'b0;
            oTimeout  <= 1'b0;
`ifdef SD_CMD_CRC7_EN
            crc       <= '0;
            crc_err   <= 1'b0;
`endif
        end else if (iEnable) begin
            oComplete <= 1'b0;
            oTimeout  <= 1'b0;
`ifdef SD_CMD_CRC7_EN
            crc_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (iStart && !iMode) begin
                        frame     <= iParallel;
                        oSerial   <= iParallel[WIDTH-1];
                        oSerialOe <= 1'b1;
                        oBusy     <= 1'b1;
                        cnt       <= CNT_W'(1);
`ifdef SD_CMD_CRC7_EN
                        crc       <= crc7_step(7'd0, iParallel[WIDTH-1]);
`endif
                        state     <= TX_SHIFT;
                    end else if (iStart && iMode) begin
                        oBusy  <= 1'b1;
                        to_cnt <= '0;
                        state  <= RX_WAIT;
                    end
                end

                TX_SHIFT: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        oSerial   <= 1'b1;
                        oSerialOe <= 1'b0;
                        oBusy     <= 1'b0;
                        oComplete <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
`ifdef SD_CMD_CRC7_EN
                        // Bits 7..1 carry the CRC computed over the header bits.
                        if (idx >= CNT_W'(8)) begin
                            oSerial <= frame[idx];
                            crc     <= crc7_step(crc, frame[idx]);
                        end else if (idx != '0) begin
                            oSerial <= crc[3'(idx - CNT_W'(1))];
                        end else begin
                            oSerial <= frame[0];
                        end
`else
                        oSerial <= frame[idx];
`endif
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_WAIT: begin
                    if (!iSerial) begin
                        frame[WIDTH-1] <= 1'b0;
                        cnt            <= CNT_W'(1);
`ifdef SD_CMD_CRC7_EN
                        crc            <= crc7_step(7'd0, 1'b0);
`endif
                        state          <= RX_SHIFT;
                    end else begin
                        to_cnt <= to_next;
                        if (TIMEOUT != 0 && to_next == TO_W'(TIMEOUT)) begin
                            oTimeout <= 1'b1;
                            oBusy    <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                RX_SHIFT: begin
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        oParallel <= {frame[WIDTH-1:1], iSerial};
                        oComplete <= 1'b1;
                        oBusy     <= 1'b0;
                        cnt       <= '0;
`ifdef SD_CMD_CRC7_EN
                        crc_err   <= (frame[7:1] != crc);
`endif
                        state     <= IDLE;
                    end else begin
                        frame[idx] <= iSerial;
`ifdef SD_CMD_CRC7_EN
                        if (idx >= CNT_W'(8)) crc <= crc7_step(crc, iSerial);
`endif
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_shift_engine.sv
// Directed bench for sd_cmd_shift_engine: frame table plus reset, timeout and clock-enable sequences.
module tb_sd_cmd_shift_engine;

    localparam int W = 48;
`ifdef SD_CMD_CRC7_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l;
    logic         en;
    logic         start;
    logic         mode;
    logic [W-1:0] par_in;
    logic         ser_in;
    logic         ser_out;
    logic         ser_oe;
    logic [W-1:0] par_out;
    logic         busy;
    logic         complete;
    logic         timeout;
    logic         crc_err;

    int n_checks = 0;
    int n_fail   = 0;

    sd_cmd_shift_engine dut (
        .iClock_SD (clk),
        .iReset    (rst_l),
        .iEnable   (en),
        .iStart    (start),
        .iMode     (mode),
        .iParallel (par_in),
        .iSerial   (ser_in),
        .oSerial   (ser_out),
        .oSerialOe (ser_oe),
        .oParallel (par_out),
        .oBusy     (busy),
        .oComplete (complete),
        .oTimeout  (timeout),
        .oCrcErr   (crc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rx;
        logic [W-1:0] data;
        logic [W-1:0] line;
        int           idle;
        logic         err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_tx(input logic [W-1:0] data, input logic [W-1:0] line);
        logic [W-1:0] l;
        l      = line;
        start  = 1'b1;
        mode   = 1'b0;
        par_in = data;
        tick();
        start  = 1'b0;
        par_in = '0;
        check("tx_busy_accept", 64'(busy), 64'd1);
        for (int k = 0; k < W; k++) begin
            if (k > 0) tick();
            check("tx_bit", 64'(ser_out), 64'(l[W-1-k]));
            check("tx_oe", 64'(ser_oe), 64'd1);
            check("tx_no_early_complete", 64'(complete), 64'd0);
        end
        tick();
        check("tx_complete", 64'(complete), 64'd1);
        check("tx_idle_line", 64'(ser_out), 64'd1);
        check("tx_oe_off", 64'(ser_oe), 64'd0);
        check("tx_busy_off", 64'(busy), 64'd0);
        tick();
        check("tx_complete_clear", 64'(complete), 64'd0);
    endtask

    task automatic run_rx(input logic [W-1:0] line, input int idle, input logic err);
        logic [W-1:0] l;
        l     = line;
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        check("rx_busy_accept", 64'(busy), 64'd1);
        check("rx_oe_off", 64'(ser_oe), 64'd0);
        for (int j = 0; j < idle; j++) begin
            ser_in = 1'b1;
            tick();
            check("rx_wait_busy", 64'(busy), 64'd1);
        end
        for (int k = 0; k < W; k++) begin
            ser_in = l[W-1-k];
            tick();
            if (k < W - 1) check("rx_no_early_complete", 64'(complete), 64'd0);
        end
        ser_in = 1'b1;
        check("rx_complete", 64'(complete), 64'd1);
        check("rx_parallel", 64'(par_out), 64'(l));
        check("rx_crc_err", 64'(crc_err), 64'(err));
        check("rx_busy_off", 64'(busy), 64'd0);
        check("rx_no_timeout", 64'(timeout), 64'd0);
        tick();
        check("rx_complete_clear", 64'(complete), 64'd0);
        check("rx_crc_err_clear", 64'(crc_err), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ref_line;
        logic [W-1:0] held;
        int           k;
        int           e;
        int           seen;

        vecs[0] = '{1'b0, 48'h400000000095, 48'h400000000095, 0, 1'b0};
        vecs[1] = '{1'b0, 48'h4000000000FF, CRC_ON ? 48'h400000000095 : 48'h4000000000FF, 0, 1'b0};
        vecs[2] = '{1'b0, 48'h770000000001, CRC_ON ? 48'h770000000065 : 48'h770000000001, 0, 1'b0};
        vecs[3] = '{1'b0, 48'h400000000001, CRC_ON ? 48'h400000000095 : 48'h400000000001, 0, 1'b0};
        vecs[4] = '{1'b1, '0, 48'h48000001AA87, 5, 1'b0};
        vecs[5] = '{1'b1, '0, 48'h48000001AA89, 0, CRC_ON};
        vecs[6] = '{1'b1, '0, 48'h7A00000000FD, 3, 1'b0};
        vecs[7] = '{1'b1, '0, 48'h510000000054, 1, 1'b0};

        rst_l  = 1'b0;
        en     = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        par_in = '0;
        ser_in = 1'b1;
        tick();
        tick();
        check("rst_serial", 64'(ser_out), 64'd1);
        check("rst_oe", 64'(ser_oe), 64'd0);
        check("rst_parallel", 64'(par_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", {61'd0, complete, timeout, crc_err}, 64'd0);
        rst_l = 1'b1;
        tick();

        // Reset while bit 10 is on the line aborts with no completion.
        start  = 1'b1;
        mode   = 1'b0;
        par_in = 48'h400000000095;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check("abort_serial", 64'(ser_out), 64'd1);
        check("abort_oe", 64'(ser_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (complete) seen++;
        end
        check("abort_no_complete", 64'(seen), 64'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rx) run_rx(vecs[i].line, vecs[i].idle, vecs[i].err);
            else            run_tx(vecs[i].data, vecs[i].line);
        end

        // Line held idle: timeout on the 64th edge after accept, last frame kept.
        held   = par_out;
        start  = 1'b1;
        mode   = 1'b1;
        ser_in = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (timeout || !busy) begin
                check("to_early", {62'd0, timeout, busy}, 64'd1);
                break;
            end
        end
        tick();
        check("to_pulse", 64'(timeout), 64'd1);
        check("to_busy_off", 64'(busy), 64'd0);
        check("to_no_complete", 64'(complete), 64'd0);
        check("to_parallel_held", 64'(par_out), 64'(held));
        tick();
        check("to_clear", 64'(timeout), 64'd0);

        // Clock enable low for 10 edges mid-TX; iStart held high throughout.
        ref_line = 48'h400000000095;
        start    = 1'b1;
        mode     = 1'b0;
        par_in   = ref_line;
        tick();
        par_in = '0;
        k = 0;
        e = 0;
        while (k < W && e < 100) begin
            e++;
            en = !(e >= 21 && e <= 30);
            tick();
            if (en) k++;
            check("en_complete", 64'(complete), 64'(k == W));
            if (k < W) begin
                check("en_bit", 64'(ser_out), 64'(ref_line[W-1-k]));
                check("en_busy", 64'(busy), 64'd1);
            end
        end
        en = 1'b1;
        check("en_complete_edge", 64'(e), 64'd58);
        check("en_busy_off_at_complete", 64'(busy), 64'd0);
        tick();
        check("en_rerequest_accepted", 64'(busy), 64'd1);
        start = 1'b0;
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
